// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace buffer: record layout, FSM states, halt encoding.
// Build with COMMIT_DMEM_EN defined to carry data-memory write fields in each record.
package commit_trace_pkg;

  localparam int CT_XLEN = 32;
  localparam int CT_RA_W = 5;
  localparam logic [31:0] HALT_INST = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Field widths track CT_XLEN/CT_RA_W; the top-level XLEN/RA_W parameters must match them.
  typedef struct packed {
    logic [CT_XLEN-1:0] pc;
    logic [CT_XLEN-1:0] inst;
    logic               halt;
    logic               reg_we;
    logic [CT_RA_W-1:0] reg_wa;
    logic [CT_XLEN-1:0] reg_wd;
`ifdef COMMIT_DMEM_EN
    logic               dmem_we;
    logic [CT_XLEN-1:0] dmem_wa;
    logic [CT_XLEN-1:0] dmem_wd;
`endif
  } commit_rec_t;

  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// DEPTH x W record storage: one synchronous write port, one asynchronous read port.
// No reset on the array; validity is tracked by the owner's pointers and count.
module trace_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-record FWFT queue (head visible the cycle after push; stall_req = !in_ready, no same-cycle slot reuse).
// Stops accepting after a halt record, drains, then parks in DONE; COMMIT_DMEM_EN adds dmem fields.
module commit_trace_buffer
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = CT_XLEN,
  parameter int RA_W  = CT_RA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [XLEN-1:0]           in_inst,
  input  logic                      in_halt,
  input  logic                      in_reg_we,
  input  logic [RA_W-1:0]           in_reg_wa,
  input  logic [XLEN-1:0]           in_reg_wd,
`ifdef COMMIT_DMEM_EN
  input  logic                      in_dmem_we,
  input  logic [XLEN-1:0]           in_dmem_wa,
  input  logic [XLEN-1:0]           in_dmem_wd,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [XLEN-1:0]           out_inst,
  output logic                      out_halt,
  output logic                      out_reg_we,
  output logic [RA_W-1:0]           out_reg_wa,
  output logic [XLEN-1:0]           out_reg_wd,
`ifdef COMMIT_DMEM_EN
  output logic                      out_dmem_we,
  output logic [XLEN-1:0]           out_dmem_wa,
  output logic [XLEN-1:0]           out_dmem_wd,
`endif
  output logic                      stall_req,
  output logic [count_w(DEPTH)-1:0] count,
  output logic                      overflow,
  output logic                      done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);
  localparam int RW = $bits(commit_rec_t);

  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [1:0]    r_state;
  logic          r_overflow;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_wa_nz;
  commit_rec_t   w_wr_rec;
  commit_rec_t   w_rd_rec;
  commit_rec_t   w_head;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign in_ready  = (r_state == S_RUN) && !w_full;
  assign stall_req = !in_ready;
  assign out_valid = !w_empty && (r_state != S_DONE);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_wa_nz   = (in_reg_wa != '0);

  // x0 writes are architecturally invisible, so strip them before they reach the host.
  always_comb begin
    w_wr_rec        = '0;
    w_wr_rec.pc     = in_pc;
    w_wr_rec.inst   = in_inst;
    w_wr_rec.halt   = in_halt;
    w_wr_rec.reg_we = in_reg_we && w_wa_nz;
    w_wr_rec.reg_wa = in_reg_wa;
    w_wr_rec.reg_wd = w_wa_nz ? in_reg_wd : '0;
`ifdef COMMIT_DMEM_EN
    w_wr_rec.dmem_we = in_dmem_we;
    w_wr_rec.dmem_wa = in_dmem_we ? in_dmem_wa : '0;
    w_wr_rec.dmem_wd = in_dmem_we ? in_dmem_wd : '0;
`endif
  end

  trace_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push && !flush),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_rec),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_rec)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_state    <= S_RUN;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_state    <= S_RUN;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (in_valid && !in_ready && (r_state == S_RUN)) r_overflow <= 1'b1;
      // DONE is entered on the edge that pops the last record, so done rises one cycle after the halt pops.
      case (r_state)
        S_RUN:   if (w_push && in_halt) r_state <= S_DRAIN;
        S_DRAIN: if (w_empty || (w_pop && r_count == CW'(1))) r_state <= S_DONE;
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign w_head     = out_valid ? w_rd_rec : '0;
  assign out_pc     = w_head.pc;
  assign out_inst   = w_head.inst;
  assign out_halt   = w_head.halt;
  assign out_reg_we = w_head.reg_we;
  assign out_reg_wa = w_head.reg_wa;
  assign out_reg_wd = w_head.reg_wd;
`ifdef COMMIT_DMEM_EN
  assign out_dmem_we = w_head.dmem_we;
  assign out_dmem_wa = w_head.dmem_wa;
  assign out_dmem_wd = w_head.dmem_wd;
`endif
  assign count    = r_count;
  assign overflow = r_overflow;
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: expected records are queued at offer time and a
// negedge monitor pops and compares them whenever the DUT hands a record to the host.
module tb_commit_trace_buffer;
  import commit_trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = count_w(DEPTH);

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [31:0]   in_inst;
  logic          in_halt;
  logic          in_reg_we;
  logic [4:0]    in_reg_wa;
  logic [31:0]   in_reg_wd;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic          out_halt;
  logic          out_reg_we;
  logic [4:0]    out_reg_wa;
  logic [31:0]   out_reg_wd;
  logic          stall_req;
  logic [CW-1:0] count;
  logic          overflow;
  logic          done;
`ifdef COMMIT_DMEM_EN
  logic          in_dmem_we;
  logic [31:0]   in_dmem_wa;
  logic [31:0]   in_dmem_wd;
  logic          out_dmem_we;
  logic [31:0]   out_dmem_wa;
  logic [31:0]   out_dmem_wd;
`endif

  commit_trace_buffer #(.DEPTH(DEPTH), .XLEN(32), .RA_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_inst    (in_inst),
    .in_halt    (in_halt),
    .in_reg_we  (in_reg_we),
    .in_reg_wa  (in_reg_wa),
    .in_reg_wd  (in_reg_wd),
`ifdef COMMIT_DMEM_EN
    .in_dmem_we (in_dmem_we),
    .in_dmem_wa (in_dmem_wa),
    .in_dmem_wd (in_dmem_wd),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .out_halt   (out_halt),
    .out_reg_we (out_reg_we),
    .out_reg_wa (out_reg_wa),
    .out_reg_wd (out_reg_wd),
`ifdef COMMIT_DMEM_EN
    .out_dmem_we (out_dmem_we),
    .out_dmem_wa (out_dmem_wa),
    .out_dmem_wd (out_dmem_wd),
`endif
    .stall_req  (stall_req),
    .count      (count),
    .overflow   (overflow),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  commit_rec_t exp_q[$];
  commit_rec_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_record: got pc %0h, expected no record", out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_pc",     out_pc,     mon_e.pc);
        chk("out_inst",   out_inst,   mon_e.inst);
        chk("out_halt",   out_halt,   mon_e.halt);
        chk("out_reg_we", out_reg_we, mon_e.reg_we);
        chk("out_reg_wa", out_reg_wa, mon_e.reg_wa);
        chk("out_reg_wd", out_reg_wd, mon_e.reg_wd);
`ifdef COMMIT_DMEM_EN
        chk("out_dmem_we", out_dmem_we, mon_e.dmem_we);
        chk("out_dmem_wa", out_dmem_wa, mon_e.dmem_wa);
        chk("out_dmem_wd", out_dmem_wd, mon_e.dmem_wd);
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one record for one cycle; acc says whether the bench expects it to be taken.
  task automatic offer(input logic [31:0] pc, input logic [31:0] inst, input logic halt,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic acc);
    commit_rec_t e;
    in_valid  = 1'b1;
    in_pc     = pc;
    in_inst   = inst;
    in_halt   = halt;
    in_reg_we = we;
    in_reg_wa = wa;
    in_reg_wd = wd;
`ifdef COMMIT_DMEM_EN
    in_dmem_we = pc[2];
    in_dmem_wa = pc + 32'h1000;
    in_dmem_wd = ~pc;
`endif
    if (acc) begin
      e        = '0;
      e.pc     = pc;
      e.inst   = inst;
      e.halt   = halt;
      e.reg_we = we && (wa != 5'd0);
      e.reg_wa = wa;
      e.reg_wd = (wa != 5'd0) ? wd : 32'd0;
`ifdef COMMIT_DMEM_EN
      e.dmem_we = pc[2];
      e.dmem_wa = pc[2] ? pc + 32'h1000 : 32'd0;
      e.dmem_wd = pc[2] ? ~pc : 32'd0;
`endif
      exp_q.push_back(e);
    end
    @(negedge clk);
    chk("in_ready", in_ready, acc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0; in_halt = 1'b0;
    in_reg_we = 1'b0; in_reg_wa = '0; in_reg_wd = '0;
`ifdef COMMIT_DMEM_EN
    in_dmem_we = 1'b0; in_dmem_wa = '0; in_dmem_wd = '0;
`endif
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count",     count,     0);
    chk("rst_done",      done,      0);
    chk("rst_overflow",  overflow,  0);
    chk("rst_out_pc",    out_pc,    0);
    #1 rst = 1'b1;
    tick(1);
    chk("rel_in_ready",  in_ready,  1);
    chk("rel_stall_req", stall_req, 0);

    // Three records held, then drained in order.
    offer(32'h0, 32'h0000_0013, 0, 1, 5'd1, 32'h11, 1);
    offer(32'h4, 32'h0000_0093, 0, 1, 5'd2, 32'h22, 1);
    offer(32'h8, 32'h0000_0113, 0, 1, 5'd3, 32'h33, 1);
    @(negedge clk);
    chk("t1_count",     count,     3);
    chk("t1_head_pc",   out_pc,    32'h0);
    chk("t1_out_valid", out_valid, 1);
    @(posedge clk); #1 out_ready = 1'b1;
    tick(3);
    @(negedge clk);
    chk("t1_count_end", count,     0);
    chk("t1_valid_end", out_valid, 0);
    chk("t1_pc_empty",  out_pc,    0);

    // Fill to DEPTH, overflow on the ninth offer, one pop reopens the input.
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      offer(32'h100 + 32'(4 * i), 32'h0000_0013, 0, 1, 5'(i + 1), 32'h200 + 32'(i), 1);
    @(negedge clk);
    chk("t2_count_full", count,     8);
    chk("t2_in_ready",   in_ready,  0);
    chk("t2_stall_req",  stall_req, 1);
    @(posedge clk); #1;
    offer(32'h1FC, 32'h0000_0013, 0, 1, 5'd9, 32'h999, 0);
    chk("t2_overflow",   overflow,  1);
    chk("t2_count_keep", count,     8);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_no_same_cycle_reuse", in_ready, 0);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("t2_ready_after_pop", in_ready, 1);
    chk("t2_count_7",         count,    7);
    @(posedge clk); #1 out_ready = 1'b1;
    tick(7);
    @(negedge clk);
    chk("t2_count_drained", count, 0);
    @(posedge clk); #1 flush = 1'b1; out_ready = 1'b0;
    tick(1);
    flush = 1'b0;
    chk("t2_flush_overflow", overflow, 0);

    // Streaming: 20 records through with the host always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      offer(32'h400 + 32'(4 * i), 32'h0000_0033, 0, 1, 5'(i + 1), 32'hA000 + 32'(i), 1);
      chk("t3_count_stream", count, 1);
    end
    tick(1);
    @(negedge clk);
    chk("t3_count_end", count,    0);
    chk("t3_overflow",  overflow, 0);

    // Write to x0 is normalised away.
    @(posedge clk); #1 out_ready = 1'b0;
    offer(32'h500, 32'h0000_0013, 0, 1, 5'd0, 32'hDEAD, 1);
    @(negedge clk);
    chk("t4_out_valid", out_valid,  1);
    chk("t4_reg_we",    out_reg_we, 0);
    chk("t4_reg_wd",    out_reg_wd, 0);
    chk("t4_reg_wa",    out_reg_wa, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;

    // Halt: input closes, drain, DONE one cycle after the halt record pops.
    offer(32'h600, 32'h0000_0013, 0, 1, 5'd4, 32'h44, 1);
    offer(32'h604, 32'h0000_0013, 0, 1, 5'd5, 32'h55, 1);
    offer(32'h608, HALT_INST, 1, 0, 5'd0, 32'h0, 1);
    offer(32'h60C, 32'h0000_0013, 0, 1, 5'd6, 32'h66, 0);
    offer(32'h610, 32'h0000_0013, 0, 1, 5'd7, 32'h77, 0);
    chk("t5_overflow_drain", overflow, 0);
    chk("t5_count",          count,    3);
    chk("t5_done_early",     done,     0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("t5_done_before_pop", done,     0);
    chk("t5_head_halt",       out_halt, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_done",          done,      1);
    chk("t5_valid_done",    out_valid, 0);
    chk("t5_in_ready_done", in_ready,  0);
    chk("t5_count_done",    count,     0);
    @(posedge clk); #1 out_ready = 1'b0;
    offer(32'h700, 32'h0000_0013, 0, 1, 5'd8, 32'h88, 0);
    chk("t5_overflow_done", overflow, 0);
    chk("t5_done_stays",    done,     1);

    // Flush out of DONE.
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("t6_done_cleared", done,     0);
    chk("t6_in_ready",     in_ready, 1);

    // Asynchronous reset with five records buffered.
    for (int i = 0; i < 5; i++)
      offer(32'h800 + 32'(4 * i), 32'h0000_0013, 0, 1, 5'(i + 10), 32'hB00 + 32'(i), 1);
    @(negedge clk);
    chk("t7_count_5", count,  5);
    chk("t7_head_pc", out_pc, 32'h800);
    #2 rst = 1'b0;
    #1;
    chk("t7_rst_valid",  out_valid,  0);
    chk("t7_rst_count",  count,      0);
    chk("t7_rst_pc",     out_pc,     0);
    chk("t7_rst_reg_wd", out_reg_wd, 0);
    exp_q.delete();
    rst = 1'b1;
    tick(1);
    chk("t7_rel_count",    count,    0);
    chk("t7_rel_in_ready", in_ready, 1);
    chk("t7_rel_done",     done,     0);
    offer(32'h900, 32'h0000_0013, 0, 1, 5'd1, 32'hC0DE, 1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
